// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT twiddle/butterfly scheduler.
package fft_pkg;

  localparam int MAX_LOG2N_DEF  = 12;
  localparam int ADDR_WIDTH_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A transform size is usable only if it has at least one butterfly
  // and fits the address space.
  function automatic logic log2n_legal(input logic [3:0] n, input int max_l);
    return (n != 4'd0) && (int'(n) <= max_l);
  endfunction

endpackage

// File: rtl/fft_bf_addr_calc.sv
// Radix-2 DIT butterfly address generator: (stage, butterfly, log2n) -> sample pair + twiddle index.
module fft_bf_addr_calc import fft_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [3:0]            stage_i,
  input  logic [ADDR_WIDTH-1:0] bfly_i,
  input  logic [3:0]            log2n_i,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o
);

  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] j;
  logic [ADDR_WIDTH-1:0] grp;
  logic [3:0]            rshift;

  // Upper index has bit 'stage' clear, so the lower index is a simple OR.
  always_comb begin
    span       = ADDR_WIDTH'(1) << stage_i;
    j          = bfly_i & (span - ADDR_WIDTH'(1));
    grp        = bfly_i >> stage_i;
    addr_a_o   = (grp << (stage_i + 4'd1)) | j;
    addr_b_o   = addr_a_o | span;
    rshift     = log2n_i - 4'd1 - stage_i;
    rom_addr_o = j << rshift;
  end

endmodule

// File: rtl/fft_twiddle_sched.sv
// Butterfly/twiddle scheduler: walks stages and butterflies, drives a sync twiddle ROM
// and presents descriptors aligned with the ROM read data.
module fft_twiddle_sched import fft_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_LOG2N  = MAX_LOG2N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            log2n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_wr_ena,
  output logic                  bf_valid,
  input  logic                  bf_ready,
  output logic [ADDR_WIDTH-1:0] bf_addr_a,
  output logic [ADDR_WIDTH-1:0] bf_addr_b,
  output logic [3:0]            bf_stage,
  output logic                  bf_last
);

  if (DATA_WIDTH < 1 || ADDR_WIDTH < MAX_LOG2N || MAX_LOG2N > 15) begin : g_param_chk
    $error("fft_twiddle_sched: illegal parameter combination");
  end

  state_e                state_q;
  logic [3:0]            n_q;
  logic [3:0]            s_q;
  logic [ADDR_WIDTH-1:0] b_q;
  logic [ADDR_WIDTH-1:0] half_m1;

  // vld_pipe_q[0]: issued descriptor (ROM address launched); [1]: presented descriptor
  logic [1:0]            vld_pipe_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q, p_a_q, p_b_q;
  logic [3:0]            p_stage_q;
  logic                  p_last_q;
  logic [ADDR_WIDTH-1:0] bf_rom_q, bf_a_q, bf_b_q;
  logic [3:0]            bf_stage_q;
  logic                  bf_last_q;
  logic                  busy_q, done_q, err_q;

  logic [ADDR_WIDTH-1:0] calc_a, calc_b, calc_rom;
  logic                  adv, issue, last_iss, hs_last, stall;

  fft_bf_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH)) u_calc (
    .stage_i    (s_q),
    .bfly_i     (b_q),
    .log2n_i    (n_q),
    .addr_a_o   (calc_a),
    .addr_b_o   (calc_b),
    .rom_addr_o (calc_rom)
  );

  assign half_m1  = (ADDR_WIDTH'(1) << (n_q - 4'd1)) - ADDR_WIDTH'(1);
  assign last_iss = (s_q == n_q - 4'd1) && (b_q == half_m1);
  assign stall    = vld_pipe_q[1] && !bf_ready;
  assign adv      = !stall;
  assign issue    = (state_q == ST_RUN) && adv;
  assign hs_last  = vld_pipe_q[1] && bf_ready && bf_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      s_q        <= '0;
      b_q        <= '0;
      vld_pipe_q <= '0;
      rom_addr_q <= '0;
      p_a_q      <= '0;
      p_b_q      <= '0;
      p_stage_q  <= '0;
      p_last_q   <= 1'b0;
      bf_rom_q   <= '0;
      bf_a_q     <= '0;
      bf_b_q     <= '0;
      bf_stage_q <= '0;
      bf_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q    <= ST_IDLE;
        busy_q     <= 1'b0;
        vld_pipe_q <= '0;
        s_q        <= '0;
        b_q        <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (log2n_legal(log2n, MAX_LOG2N)) begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                n_q     <= log2n;
                s_q     <= '0;
                b_q     <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_RUN, ST_DRAIN: begin
            if (state_q == ST_DRAIN && hs_last) begin
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              vld_pipe_q <= '0;
              bf_last_q  <= 1'b0;
            end else if (adv) begin
              vld_pipe_q <= {vld_pipe_q[0], issue};
              bf_rom_q   <= rom_addr_q;
              bf_a_q     <= p_a_q;
              bf_b_q     <= p_b_q;
              bf_stage_q <= p_stage_q;
              bf_last_q  <= p_last_q;
              if (issue) begin
                rom_addr_q <= calc_rom;
                p_a_q      <= calc_a;
                p_b_q      <= calc_b;
                p_stage_q  <= s_q;
                p_last_q   <= last_iss;
                if (last_iss) begin
                  state_q <= ST_DRAIN;
                  s_q     <= '0;
                  b_q     <= '0;
                end else if (b_q == half_m1) begin
                  b_q <= '0;
                  s_q <= s_q + 4'd1;
                end else begin
                  b_q <= b_q + ADDR_WIDTH'(1);
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // While stalled the ROM must keep reading the presented descriptor's twiddle,
  // otherwise it reads the next (already issued) one.
  assign rom_addr   = stall ? bf_rom_q : rom_addr_q;
  assign rom_wr_ena = 1'b0;
  assign bf_valid   = vld_pipe_q[1];
  assign bf_addr_a  = bf_a_q;
  assign bf_addr_b  = bf_b_q;
  assign bf_stage   = bf_stage_q;
  assign bf_last    = bf_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Scoreboard bench for fft_twiddle_sched: directed transforms, stalls, errors, abort and reset.
module tb_fft_twiddle_sched;
  localparam int AW = 12;

  typedef struct {
    int a;
    int b;
    int rom;
    int stg;
    int last;
  } desc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          bf_ready = 1'b0;
  logic [3:0]    log2n = 4'd0;
  logic          busy, done, err, rom_wr_ena, bf_valid, bf_last;
  logic [AW-1:0] rom_addr, bf_addr_a, bf_addr_b;
  logic [3:0]    bf_stage;
  logic [AW-1:0] rom_q;

  desc_t exp_q[$];
  desc_t e_m;
  desc_t last_got;
  int    nvec = 0, nerr = 0, pops = 0, done_cnt = 0, err_cnt = 0;
  logic  stall_prev = 1'b0;
  int    held_desc = 0, held_rom = 0;

  int t8a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int t8b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int t8k[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_twiddle_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .MAX_LOG2N(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .log2n      (log2n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rom_addr   (rom_addr),
    .rom_wr_ena (rom_wr_ena),
    .bf_valid   (bf_valid),
    .bf_ready   (bf_ready),
    .bf_addr_a  (bf_addr_a),
    .bf_addr_b  (bf_addr_b),
    .bf_stage   (bf_stage),
    .bf_last    (bf_last)
  );

  always #5 clk = ~clk;

  // Identity twiddle ROM with one-cycle synchronous read.
  always @(posedge clk) rom_q <= rom_addr;

  task automatic chk(input string nm, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic push8();
    for (int i = 0; i < 12; i++)
      exp_q.push_back('{t8a[i], t8b[i], t8k[i], i / 4, (i == 11) ? 1 : 0});
  endtask

  task automatic push_model(input int n);
    int nn, hs, j, g;
    nn = 1 << n;
    for (int s = 0; s < n; s++) begin
      hs = 1 << s;
      for (int b = 0; b < nn / 2; b++) begin
        j = b % hs;
        g = b / hs;
        exp_q.push_back('{g * 2 * hs + j, g * 2 * hs + j + hs, j * (1 << (n - 1 - s)), s,
                          (s == n - 1 && b == nn / 2 - 1) ? 1 : 0});
      end
    end
  endtask

  task automatic kick(input logic [3:0] n);
    @(posedge clk); #1;
    log2n = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: always ready; 1: toggle each cycle (plus a stray start); 2: two-on/two-off
  task automatic run(input int mode, input int lim);
    int k = 0;
    while (!done && k < lim) begin
      case (mode)
        0:       bf_ready = 1'b1;
        1:       bf_ready = ((k % 2) == 1);
        default: bf_ready = ((k % 4) < 2);
      endcase
      if (mode == 1 && k == 5) begin
        start = 1'b1;
        log2n = 4'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (rst_n && bf_valid) begin
      if (stall_prev) chk("desc_hold", {bf_addr_a, bf_addr_b, bf_stage, bf_last}, held_desc);
      if (bf_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_desc", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          chk("bf_addr_a", bf_addr_a, e_m.a);
          chk("bf_addr_b", bf_addr_b, e_m.b);
          chk("bf_stage", bf_stage, e_m.stg);
          chk("bf_last", bf_last, e_m.last);
          chk("rom_data", rom_q, e_m.rom);
          last_got = '{bf_addr_a, bf_addr_b, rom_q, bf_stage, bf_last};
          pops++;
        end
      end
    end
    if (rst_n && bf_valid && !bf_ready) begin
      if (stall_prev) chk("rom_hold", rom_addr, held_rom);
      if (exp_q.size() != 0) chk("rom_stall", rom_addr, exp_q[0].rom);
      stall_prev = 1'b1;
      held_desc  = {bf_addr_a, bf_addr_b, bf_stage, bf_last};
      held_rom   = rom_addr;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, dc, ec;
    // reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bf_valid", bf_valid, 0);
    chk("rst_bf_last", bf_last, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_addr_a", bf_addr_a, 0);
    chk("rst_addr_b", bf_addr_b, 0);
    chk("rst_stage", bf_stage, 0);
    chk("rst_wr_ena", rom_wr_ena, 0);
    #10 rst_n = 1'b1;

    // N=8, always ready: exact latency and 12 back-to-back descriptors
    bf_ready = 1'b1;
    push8();
    kick(4'd3);
    chk("n8_busy", busy, 1);
    chk("n8_lat0", bf_valid, 0);
    @(posedge clk); #1;
    chk("n8_lat1", bf_valid, 0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("n8_stream", bf_valid, 1);
      if (i == 11) chk("n8_last_flag", bf_last, 1);
    end
    @(posedge clk); #1;
    chk("n8_done", done, 1);
    chk("n8_valid_drop", bf_valid, 0);
    chk("n8_busy_drop", busy, 0);
    chk("n8_queue", exp_q.size(), 0);

    // N=8, ready toggling, with an ignored start mid-run
    push8();
    bf_ready = 1'b0;
    kick(4'd3);
    run(1, 100);
    chk("n8t_wr_ena", rom_wr_ena, 0);

    // illegal sizes
    foreach (t8a[i]) if (i < 2) begin
      ec = err_cnt;
      kick((i == 0) ? 4'd0 : 4'd13);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", bf_valid, 0);
      @(posedge clk); #1;
      chk("err_one_cycle", err, 0);
      chk("err_busy2", busy, 0);
      chk("err_count", err_cnt - ec, 1);
    end

    // N=4096 full run
    push_model(12);
    kick(4'd12);
    run(0, 30000);
    chk("n4096_a", last_got.a, 2047);
    chk("n4096_b", last_got.b, 4095);
    chk("n4096_rom", last_got.rom, 2047);
    chk("n4096_stage", last_got.stg, 11);
    chk("n4096_last", last_got.last, 1);

    // abort at the 5th descriptor of N=16, then a clean restart
    push_model(4);
    pops = 0;
    bf_ready = 1'b1;
    kick(4'd4);
    k = 0;
    while (!(bf_valid && pops == 4) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_reach", pops, 4);
    dc = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", bf_valid, 0);
    exp_q.delete();
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, dc);
    push_model(4);
    kick(4'd4);
    run(0, 100);

    // async reset in the middle of N=32 with two-cycle stalls
    push_model(5);
    pops = 0;
    kick(4'd5);
    k = 0;
    while (pops < 10 && k < 200) begin
      bf_ready = ((k % 4) < 2);
      @(posedge clk); #1;
      k++;
    end
    chk("rst_mid_progress", (pops >= 10) ? 1 : 0, 1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstm_busy", busy, 0);
    chk("rstm_valid", bf_valid, 0);
    chk("rstm_rom", rom_addr, 0);
    chk("rstm_addr_a", bf_addr_a, 0);
    chk("rstm_addr_b", bf_addr_b, 0);
    chk("rstm_stage", bf_stage, 0);
    chk("rstm_last", bf_last, 0);
    exp_q.delete();
    #20 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bf_ready = ((i % 2) == 0);
      @(posedge clk); #1;
    end
    chk("rstm_idle_busy", busy, 0);
    chk("rstm_no_done", done_cnt, dc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_sched.md
FFT_TWIDDLE_SCHED -- requirements
Module: fft_twiddle_sched

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 32, twiddle word width (passed through, not stored).
- ADDR_WIDTH, 12, twiddle-ROM and sample address width.
- MAX_LOG2N, 12, largest supported FFT size exponent.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a transform; sampled only in IDLE.
- abort, in, 1, synchronous cancel.
- log2n, in, 4, FFT size exponent; captured on accepted start.
- busy, out, 1, high in RUN/DRAIN.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, one-cycle pulse on start with illegal log2n.
- rom_addr, out, ADDR_WIDTH, twiddle ROM address.
- rom_wr_ena, out, 1, tied 0.
- bf_valid, out, 1, butterfly descriptor valid; aligned with ROM data.
- bf_ready, in, 1, downstream accepts descriptor.
- bf_addr_a, out, ADDR_WIDTH, upper butterfly sample index.
- bf_addr_b, out, ADDR_WIDTH, lower butterfly sample index.
- bf_stage, out, 4, stage of current descriptor.
- bf_last, out, 1, last descriptor of transform.

Function
REQ-003 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE->RUN: on start with 1 <= log2n <= MAX_LOG2N.
- Illegal log2n (0 or > MAX_LOG2N): pulse err, stay in IDLE.
REQ-004 SHALL ignore start outside IDLE.
REQ-005 SHALL use radix-2 DIT ordering, N = 2^log2n; counters: stage s from 0 to log2n-1 (outer), butterfly b from 0 to N/2-1 (inner).
REQ-006 SHALL compute, for each (s, b):
- H = 2^s; j = b mod H; g = b >> s.
- a = g*2H + j; bf_addr_b = a + H.
- rom_addr = j << (log2n-1-s).
REQ-007 SHALL perform an "issue" (register rom_addr, a, b, s, last; advance counters) in RUN when !bf_valid or bf_ready.
REQ-008 SHALL register bf_valid/bf_addr_a/bf_addr_b/bf_stage/bf_last one edge after issue, so they coincide with the ROM's 1-cycle synchronous read data.
REQ-009 SHALL, while bf_valid && !bf_ready, hold rom_addr and all bf_* outputs stable, so the ROM re-reads the same word.
REQ-010 SHALL make the RUN->DRAIN transition when the issue of s = log2n-1, b = N/2-1 occurs.
REQ-011 SHALL, in DRAIN, return to IDLE and pulse done on the edge after the bf_last handshake (bf_valid && bf_ready && bf_last); bf_valid drops the same edge.
REQ-012 SHALL make abort in any state force IDLE next edge: bf_valid=0, counters cleared, no done pulse. abort has priority over start and the handshake.
REQ-013 SHALL issue exactly (N/2)*log2n descriptors per transform with no duplicates or gaps under arbitrary bf_ready patterns.
REQ-014 SHALL support log2n=1: single descriptor a=0, b=1, rom_addr=0, bf_last=1.

Reset
REQ-015 SHALL, on rst_n low asynchronously, set state IDLE and zero all counters, busy, done, err, bf_valid, bf_last, rom_addr, bf_addr_a, bf_addr_b, bf_stage; rom_wr_ena is always 0.
REQ-016 SHALL make rst_n assertion mid-transform discard all progress; after release, no descriptor is emitted until a new start.

Structure
REQ-017 SHALL place the FSM state encoding and the MAX_LOG2N/ADDR_WIDTH defaults in shared package fft_pkg.
REQ-018 SHALL have one natural sub-module, fft_bf_addr_calc: combinational (s, b, log2n) -> (a, b, rom_addr). The FSM, counters and output registers stay in the top level.

Verification
REQ-019 SHALL be verified with the following directed scenarios:
- N=8, bf_ready=1, start: bf_valid high 12 consecutive cycles starting 2 cycles after start, in this order:
  - stage 0: (0,1,k0) (2,3,k0) (4,5,k0) (6,7,k0)
  - stage 1: (0,2,k0) (1,3,k2) (4,6,k0) (5,7,k2)
  - stage 2: (0,4,k0) (1,5,k1) (2,6,k2) (3,7,k3)
  - bf_last on the 12th descriptor; done 1 cycle later.
- N=8, bf_ready toggled 1/0 every cycle: same 12 descriptors in the same order; rom_addr and bf_* stable during every stall.
- log2n=0 and log2n=13 start: err pulse, busy stays 0, bf_valid never asserted.
- N=4096: 24576 descriptors; the final one is a=2047, b=4095, rom_addr=2047, stage 11.
- abort asserted at the 5th descriptor of N=16: next cycle busy=0, bf_valid=0, no done; a subsequent start gives the full sequence from (0,1,k0).
- rst_n pulsed low mid-run for N=32: all outputs 0 immediately; no output activity until the next start.
